// File: rtl/shift_reg_pkg.sv
// Shared definitions for the 4-bit mode-controlled shift register and its
// command sequencer: mode encoding, controller state encoding, default sizes.
package shift_reg_pkg;

    // Shift register mode encoding (cmd_op reuses it, 00 meaning READ)
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_ROL  = 2'b10;
    localparam logic [1:0] MODE_SHR  = 2'b11;

    // Default register width and step-count width
    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 3;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        CAPT = 2'b10,
        RESP = 2'b11
    } state_t;

endpackage

// File: rtl/shift_reg.sv
// Mode-controlled shift register: hold, parallel load, rotate left,
// shift right with SI entering the MSB. Active-high asynchronous reset.
import shift_reg_pkg::*;

module shift_reg #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       M,
    input  logic [WIDTH-1:0] D,
    input  logic             SI,
    output logic [WIDTH-1:0] Q
);

    // Register update selected by the mode bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Q <= '0;
        end else begin
            case (M)
                MODE_HOLD: Q <= Q;
                MODE_LOAD: Q <= D;
                MODE_ROL:  Q <= {Q[WIDTH-2:0], Q[WIDTH-1]};
                MODE_SHR:  Q <= {SI, Q[WIDTH-1:1]};
                default:   Q <= Q;
            endcase
        end
    end

endmodule

// File: rtl/shift_reg_ctrl.sv
// Command sequencer for the mode-controlled shift register. Accepts one
// command over valid/ready, drives M/D/SI for exactly as many cycles as the
// command needs, then captures Q and returns it with a one-cycle pulse.
// The register contents themselves are never reset from here.
import shift_reg_pkg::*;

module shift_reg_ctrl #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             cmd_si,
    output logic [1:0]       sr_m,
    output logic [WIDTH-1:0] sr_d,
    output logic             sr_si,
    input  logic [WIDTH-1:0] sr_q,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_q,
    output logic             busy
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             needs_run;

    // LOAD always takes one RUN cycle; ROL/SHR take cnt cycles; READ and
    // zero-step shifts go straight to capture.
    assign needs_run = (cmd_op == MODE_LOAD) || (cmd_op[1] && (cmd_cnt != '0));

    assign cmd_ready = (state == IDLE);
    assign busy      = ~cmd_ready;

    // Sequencer FSM; sr_* are registered so the latched command drives the
    // register with no combinational path from the command inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            sr_m      <= MODE_HOLD;
            sr_d      <= '0;
            sr_si     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    if (cmd_valid) begin
                        if (needs_run) begin
                            state <= RUN;
                            sr_m  <= cmd_op;
                            sr_d  <= (cmd_op == MODE_LOAD) ? cmd_data : '0;
                            sr_si <= (cmd_op == MODE_SHR) ? cmd_si : 1'b0;
                            cnt   <= (cmd_op == MODE_LOAD) ? CNT_W'(1) : cmd_cnt;
                        end else begin
                            state <= CAPT;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        // Last step: return the register to hold for capture
                        state <= CAPT;
                        sr_m  <= MODE_HOLD;
                        sr_d  <= '0;
                        sr_si <= 1'b0;
                    end
                end
                CAPT: begin
                    rsp_q     <= sr_q;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Directed bench for shift_reg_ctrl driving a shift_reg instance.
module tb_shift_reg_ctrl;
    import shift_reg_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [2:0] cmd_cnt;
    logic       cmd_si;
    logic [1:0] sr_m;
    logic [3:0] sr_d;
    logic       sr_si;
    logic [3:0] sr_q;
    logic       rsp_valid;
    logic [3:0] rsp_q;
    logic       busy;

    int vectors = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    shift_reg_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_cnt(cmd_cnt), .cmd_si(cmd_si),
        .sr_m(sr_m), .sr_d(sr_d), .sr_si(sr_si), .sr_q(sr_q),
        .rsp_valid(rsp_valid), .rsp_q(rsp_q), .busy(busy)
    );

    shift_reg #(.WIDTH(4)) sreg (
        .clk(clk), .reset(~reset), .M(sr_m), .D(sr_d), .SI(sr_si), .Q(sr_q)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outputs expected while idle (or held in reset)
    task automatic chk_idle(input string tag, input logic [3:0] exp_rsp_q);
        chk({tag, "_ready"}, 8'(cmd_ready), 8'd1);
        chk({tag, "_busy"},  8'(busy),      8'd0);
        chk({tag, "_m"},     8'(sr_m),      8'd0);
        chk({tag, "_d"},     8'(sr_d),      8'd0);
        chk({tag, "_si"},    8'(sr_si),     8'd0);
        chk({tag, "_rv"},    8'(rsp_valid), 8'd0);
        chk({tag, "_rq"},    8'(rsp_q),     8'(exp_rsp_q));
    endtask

    // Issue one command and check every cycle through to the response.
    // qseq holds the expected Q after each RUN step, step 0 in the low nibble.
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [3:0] data,
                           input logic [2:0] cnt, input logic si, input int n,
                           input logic [1:0] exp_m, input logic [3:0] exp_d,
                           input logic exp_si, input logic [27:0] qseq,
                           input logic [3:0] exp_rsp, input bit pulse_busy);
        cmd_op = op; cmd_data = data; cmd_cnt = cnt; cmd_si = si;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cmd_op = 2'b00; cmd_data = 4'h0; cmd_cnt = 3'd0; cmd_si = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_run%0d_m", tag, i),  8'(sr_m),  8'(exp_m));
            chk($sformatf("%s_run%0d_d", tag, i),  8'(sr_d),  8'(exp_d));
            chk($sformatf("%s_run%0d_si", tag, i), 8'(sr_si), 8'(exp_si));
            chk($sformatf("%s_run%0d_busy", tag, i), 8'(busy), 8'd1);
            chk($sformatf("%s_run%0d_rdy", tag, i), 8'(cmd_ready), 8'd0);
            if (pulse_busy && i == 1) cmd_valid = 1'b1;
            tick();
            cmd_valid = 1'b0;
            chk($sformatf("%s_q%0d", tag, i), 8'(sr_q), 8'(qseq[i*4 +: 4]));
        end
        chk({tag, "_capt_m"},   8'(sr_m),      8'd0);
        chk({tag, "_capt_rdy"}, 8'(cmd_ready), 8'd0);
        chk({tag, "_capt_rv"},  8'(rsp_valid), 8'd0);
        tick();
        chk({tag, "_resp_rv"},  8'(rsp_valid), 8'd1);
        chk({tag, "_resp_rq"},  8'(rsp_q),     8'(exp_rsp));
        chk({tag, "_resp_rdy"}, 8'(cmd_ready), 8'd0);
        chk({tag, "_resp_m"},   8'(sr_m),      8'd0);
        tick();
        chk({tag, "_done_rv"},  8'(rsp_valid), 8'd0);
        chk({tag, "_done_rdy"}, 8'(cmd_ready), 8'd1);
        chk({tag, "_done_rq"},  8'(rsp_q),     8'(exp_rsp));
        chk({tag, "_done_q"},   8'(sr_q),      8'(exp_rsp));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset held with a command offered; nothing is accepted
        reset = 1'b0; cmd_valid = 1'b1; cmd_op = MODE_LOAD; cmd_data = 4'hF;
        cmd_cnt = 3'd0; cmd_si = 1'b0;
        tick();
        chk_idle("rst_a", 4'h0);
        tick();
        chk_idle("rst_b", 4'h0);
        chk("rst_q", 8'(sr_q), 8'h0);
        cmd_valid = 1'b0;
        reset = 1'b1;
        tick();
        chk_idle("rel", 4'h0);

        // 2: LOAD 1101
        run_cmd("load", MODE_LOAD, 4'b1101, 3'd5, 1'b1, 1, 2'b01, 4'b1101, 1'b0,
                28'h000000D, 4'b1101, 1'b0);

        // 3: SHR cnt=2 si=1 from 1101 -> 1110, 1111
        run_cmd("shr2", MODE_SHR, 4'b0101, 3'd2, 1'b1, 2, 2'b11, 4'b0000, 1'b1,
                28'h00000FE, 4'b1111, 1'b0);

        // 4: LOAD 1011 then ROL cnt=5 with a busy-time valid pulse
        run_cmd("load2", MODE_LOAD, 4'b1011, 3'd0, 1'b0, 1, 2'b01, 4'b1011, 1'b0,
                28'h000000B, 4'b1011, 1'b0);
        run_cmd("rol5", MODE_ROL, 4'b1111, 3'd5, 1'b1, 5, 2'b10, 4'b0000, 1'b0,
                28'h007BDE7, 4'b0111, 1'b1);

        // 5: READ and zero-step SHR leave Q=0111 untouched
        run_cmd("read", 2'b00, 4'b1111, 3'd3, 1'b1, 0, 2'b00, 4'b0000, 1'b0,
                28'h0, 4'b0111, 1'b0);
        run_cmd("shr0", MODE_SHR, 4'b1111, 3'd0, 1'b1, 0, 2'b00, 4'b0000, 1'b0,
                28'h0, 4'b0111, 1'b0);

        // 6: LOAD 0001, ROL cnt=7 aborted by reset during the third RUN cycle
        run_cmd("load3", MODE_LOAD, 4'b0001, 3'd0, 1'b0, 1, 2'b01, 4'b0001, 1'b0,
                28'h0000001, 4'b0001, 1'b0);
        cmd_op = MODE_ROL; cmd_cnt = 3'd7; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("abort_run0_m", 8'(sr_m), 8'(MODE_ROL));
        tick();
        chk("abort_q1", 8'(sr_q), 8'b0010);
        tick();
        chk("abort_q2", 8'(sr_q), 8'b0100);
        chk("abort_run2_m", 8'(sr_m), 8'(MODE_ROL));
        chk("abort_run2_busy", 8'(busy), 8'd1);
        reset = 1'b0;
        #1;
        chk_idle("abort_now", 4'h0);
        tick();
        chk_idle("abort_held", 4'h0);
        reset = 1'b1;
        tick();
        chk_idle("abort_rel1", 4'h0);
        tick();
        chk_idle("abort_rel2", 4'h0);
        run_cmd("load4", MODE_LOAD, 4'b1010, 3'd0, 1'b0, 1, 2'b01, 4'b1010, 1'b0,
                28'h000000A, 4'b1010, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
